// File: rtl/df_actor_responder_if.sv
// Actor invocation handshake plus input/output FIFO signals.
// master: controller/FIFO side, slave: actor side.
interface df_actor_responder_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 8
);
   logic                   ap_start;
   logic                   ap_done;
   logic                   ap_idle;
   logic                   ap_ready;
   logic [31:0]            ap_return;
   logic [COUNT_WIDTH-1:0] in_count;
   logic                   in_empty_n;
   logic [DATA_WIDTH-1:0]  in_dout;
   logic                   in_read;
   logic [COUNT_WIDTH-1:0] out_space;
   logic                   out_full_n;
   logic [DATA_WIDTH-1:0]  out_din;
   logic                   out_write;

   modport master (
      output ap_start, in_count, in_empty_n, in_dout,
      output out_space, out_full_n,
      input  ap_done, ap_idle, ap_ready, ap_return,
      input  in_read, out_din, out_write
   );

   modport slave (
      input  ap_start, in_count, in_empty_n, in_dout,
      input  out_space, out_full_n,
      output ap_done, ap_idle, ap_ready, ap_return,
      output in_read, out_din, out_write
   );
endinterface

// File: rtl/df_actor_responder.sv
// Callee end of the ap_start/ap_done/ap_return actor handshake.
// Ports: ap_clk, ap_rst (sync, high), bus (slave modport),
// guard (only when DF_ACTOR_GUARD_EN is defined).
module df_actor_responder #(
   parameter int DATA_WIDTH   = 32,
   parameter int COUNT_WIDTH  = 8,
   parameter int TOKENS_IN    = 2,
   parameter int TOKENS_OUT   = 1,
   parameter int EXEC_LATENCY = 3,
   parameter int OFFSET       = 1
) (
   input logic ap_clk,
   input logic ap_rst,
`ifdef DF_ACTOR_GUARD_EN
   input logic guard,
`endif
   df_actor_responder_if.slave bus
);

   localparam logic [31:0] RC_WAIT_INPUT  = 32'd2;
   localparam logic [31:0] RC_WAIT_OUTPUT = 32'd3;
`ifdef DF_ACTOR_GUARD_EN
   localparam logic [31:0] RC_WAIT_GUARD  = 32'd4;
`endif
   localparam logic [31:0] RC_EXECUTED    = 32'd5;

   localparam logic [15:0] RD_LAST = 16'(TOKENS_IN - 1);
   localparam logic [15:0] EX_LAST = 16'(EXEC_LATENCY - 1);
   localparam logic [15:0] WR_LAST = 16'(TOKENS_OUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_READ, S_EXEC, S_WRITE, S_DONE
   } state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] acc, acc_nxt;
   // One counter serves read, exec and write phases in turn.
   logic [15:0]           cnt, cnt_nxt;
   logic [31:0]           ret, ret_nxt;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state <= S_IDLE;
         acc   <= '0;
         cnt   <= '0;
         ret   <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         ret   <= ret_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      acc_nxt       = acc;
      cnt_nxt       = cnt;
      ret_nxt       = ret;
      bus.in_read   = 1'b0;
      bus.out_write = 1'b0;
      bus.out_din   = '0;
      unique case (state)
         S_IDLE: begin
            if (bus.ap_start) begin
               state_nxt = S_CHECK;
               acc_nxt   = '0;
               cnt_nxt   = '0;
            end
         end
         S_CHECK: begin
            cnt_nxt = '0;
            if (bus.in_count < COUNT_WIDTH'(TOKENS_IN)) begin
               ret_nxt   = RC_WAIT_INPUT;
               state_nxt = S_DONE;
            end else if (bus.out_space < COUNT_WIDTH'(TOKENS_OUT)) begin
               ret_nxt   = RC_WAIT_OUTPUT;
               state_nxt = S_DONE;
`ifdef DF_ACTOR_GUARD_EN
            end else if (!guard) begin
               ret_nxt   = RC_WAIT_GUARD;
               state_nxt = S_DONE;
`endif
            end else begin
               state_nxt = S_READ;
            end
         end
         S_READ: begin
            bus.in_read = bus.in_empty_n;
            if (bus.in_empty_n) begin
               acc_nxt = acc + bus.in_dout;
               if (cnt == RD_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = S_EXEC;
               end else begin
                  cnt_nxt = cnt + 16'd1;
               end
            end
         end
         S_EXEC: begin
            if (cnt == EX_LAST) begin
               cnt_nxt   = '0;
               state_nxt = S_WRITE;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         S_WRITE: begin
            bus.out_din   = acc + DATA_WIDTH'(OFFSET)
                          + DATA_WIDTH'(cnt);
            bus.out_write = bus.out_full_n;
            if (bus.out_full_n) begin
               if (cnt == WR_LAST) begin
                  cnt_nxt   = '0;
                  ret_nxt   = RC_EXECUTED;
                  state_nxt = S_DONE;
               end else begin
                  cnt_nxt = cnt + 16'd1;
               end
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.ap_done   = (state == S_DONE);
   assign bus.ap_ready  = (state == S_DONE);
   assign bus.ap_idle   = (state == S_IDLE);
   assign bus.ap_return = ret;

endmodule

// File: tb/tb_df_actor_responder.sv
// Scoreboard bench for df_actor_responder.
// Stimulus pushes expected ap_done/out_din; a monitor pops and compares.
module tb_df_actor_responder;
   localparam int DW = 32;
   localparam int CW = 8;

   typedef struct {
      logic [31:0] code;
      int          cyc;
   } done_t;

   logic ap_clk = 1'b0;
   logic ap_rst = 1'b1;
`ifdef DF_ACTOR_GUARD_EN
   logic guard  = 1'b1;
`endif

   always #5 ap_clk = ~ap_clk;

   df_actor_responder_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

   df_actor_responder dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
`ifdef DF_ACTOR_GUARD_EN
      .guard  (guard),
`endif
      .bus    (bus.slave)
   );

   int cyc = 0;
   always @(posedge ap_clk) cyc <= cyc + 1;

   logic [DW-1:0] mem [0:31];
   int rp = 0;
   int wp = 0;
   int in_lo = -1, in_hi = -1, out_lo = -1, out_hi = -1;

   always @(posedge ap_clk) if (bus.in_read) rp <= rp + 1;

   always_comb begin
      bus.in_empty_n = (rp < wp) && !(cyc >= in_lo && cyc <= in_hi);
      bus.in_dout    = (rp < wp) ? mem[rp[4:0]] : '0;
      bus.out_full_n = !(cyc >= out_lo && cyc <= out_hi);
   end

   done_t         dq [$];
   logic [DW-1:0] wq [$];
   int n_vec = 0;
   int n_err = 0;
   int wr_seen = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   always @(negedge ap_clk) begin
      done_t         d;
      logic [DW-1:0] w;
      if (bus.in_read) chk("read_when_empty", {31'd0, bus.in_empty_n}, 1);
      if (bus.out_write) begin
         wr_seen++;
         chk("write_when_full", {31'd0, bus.out_full_n}, 1);
         if (wq.size() == 0) begin
            chk("unexpected_write", 1, 0);
         end else begin
            w = wq.pop_front();
            chk("out_din", bus.out_din, w);
         end
      end
      if (bus.ap_done) begin
         chk("ap_ready", {31'd0, bus.ap_ready}, 1);
         if (dq.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            d = dq.pop_front();
            chk("ap_return", bus.ap_return, d.code);
            chk("done_cycle", cyc, d.cyc);
         end
      end
   end

   task automatic push_tok(input logic [DW-1:0] v);
      mem[wp[4:0]] = v;
      wp++;
   endtask

   task automatic invoke(input logic [31:0] code, input int lat);
      dq.push_back('{code, cyc + lat});
      bus.ap_start = 1'b1;
      @(negedge ap_clk);
      bus.ap_start = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while ((dq.size() != 0 || wq.size() != 0) && k < 200) begin
         @(negedge ap_clk);
         k++;
      end
      if (k >= 200) chk("drain_timeout", 1, 0);
      @(negedge ap_clk);
   endtask

   initial begin
      int p0, w0, s, k;
      bus.ap_start  = 1'b0;
      bus.in_count  = '0;
      bus.out_space = 8'd4;
      repeat (3) @(negedge ap_clk);
      chk("rst_idle", {31'd0, bus.ap_idle}, 1);
      chk("rst_done", {31'd0, bus.ap_done}, 0);
      chk("rst_return", bus.ap_return, 0);
      chk("rst_write", {31'd0, bus.out_write}, 0);
      chk("rst_din", bus.out_din, 0);
      ap_rst = 1'b0;
      @(negedge ap_clk);

      // T1: no input tokens
      p0 = rp;
      invoke(32'd2, 2);
      drain();
      chk("t1_pops", rp - p0, 0);

      // T2: input ok, no output space
      bus.in_count  = 8'd2;
      bus.out_space = 8'd0;
      p0 = rp;
      w0 = wr_seen;
      invoke(32'd3, 2);
      drain();
      chk("t2_pops", rp - p0, 0);
      chk("t2_writes", wr_seen - w0, 0);

      // T3: exact-boundary counts fire
      bus.out_space = 8'd1;
      push_tok(32'd5);
      push_tok(32'd7);
      wq.push_back(32'd13);
      p0 = rp;
      invoke(32'd5, 8);
      drain();
      chk("t3_pops", rp - p0, 2);

      // T4: input stall 3 cycles, output stall 2 cycles
      push_tok(32'd10);
      push_tok(32'd20);
      wq.push_back(32'd31);
      s = cyc;
      in_lo  = s + 3;
      in_hi  = s + 5;
      out_lo = s + 10;
      out_hi = s + 11;
      invoke(32'd5, 13);
      drain();
      in_lo = -1; in_hi = -1; out_lo = -1; out_hi = -1;

      // T5: wrap-around and back-to-back with ap_start held
      push_tok(32'hFFFF_FFFF);
      push_tok(32'h1);
      push_tok(32'h2);
      push_tok(32'h3);
      wq.push_back(32'h1);
      wq.push_back(32'h6);
      s = cyc;
      dq.push_back('{32'd5, s + 8});
      dq.push_back('{32'd5, s + 17});
      bus.ap_start = 1'b1;
      k = 0;
      do begin
         @(negedge ap_clk);
         k++;
      end while (!bus.ap_done && k < 50);
      if (k >= 50) chk("t5_timeout", 1, 0);
      @(negedge ap_clk);
      chk("t5_idle_after_done", {31'd0, bus.ap_idle}, 1);
      chk("t5_return_held", bus.ap_return, 5);
      @(negedge ap_clk);
      bus.ap_start = 1'b0;
      drain();

      // T6: reset during compute
      push_tok(32'd4);
      push_tok(32'd4);
      p0 = rp;
      w0 = wr_seen;
      bus.ap_start = 1'b1;
      @(negedge ap_clk);
      bus.ap_start = 1'b0;
      repeat (4) @(negedge ap_clk);
      ap_rst = 1'b1;
      @(negedge ap_clk);
      ap_rst = 1'b0;
      chk("t6_idle", {31'd0, bus.ap_idle}, 1);
      chk("t6_return_clr", bus.ap_return, 0);
      repeat (10) @(negedge ap_clk);
      chk("t6_pops", rp - p0, 2);
      chk("t6_writes", wr_seen - w0, 0);

`ifdef DF_ACTOR_GUARD_EN
      guard = 1'b0;
      push_tok(32'd1);
      push_tok(32'd2);
      p0 = rp;
      invoke(32'd4, 2);
      drain();
      chk("guard_pops", rp - p0, 0);
      guard = 1'b1;
`endif

      chk("sb_empty", dq.size() + wq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
